spi_msg_if: RTL

- Message layer directly downstream of the SPI byte interface. Consumes received bytes (rxValid/rx) and supplies the byte to transmit (tx).
- Frames each SS-low transaction as one header byte followed by DATA_BYTES payload bytes.
- Turns each message into a single register write or register read on a simple parallel register bus.
- Runs in the sysClk domain.

---
 rtl/spi_msg_if_if.sv | 22 ++
 rtl/spi_msg_if.sv | 138 +++++++++++++
 2 files changed

// File: rtl/spi_msg_if_if.sv
// Register bus between the SPI message layer (master) and the register file (slave).
// One-cycle write/read strobes; read data returns a fixed latency after rdReq.
interface spi_msg_if_if #(
  parameter int DATA_BYTES = 2
);
  logic                    wrEn;
  logic [6:0]              wrAddr;
  logic [8*DATA_BYTES-1:0] wrData;
  logic                    rdReq;
  logic [6:0]              rdAddr;
  logic [8*DATA_BYTES-1:0] rdData;

  modport master (
    output wrEn, wrAddr, wrData, rdReq, rdAddr,
    input  rdData
  );

  modport slave (
    input  wrEn, wrAddr, wrData, rdReq, rdAddr,
    output rdData
  );
endinterface

// File: rtl/spi_msg_if.sv
// SPI message layer: frames each SS-low transaction as header + DATA_BYTES payload
// and turns it into one register write or read on the parallel register bus.
module spi_msg_if #(
  parameter int         DATA_BYTES  = 2,
  parameter int         RD_LATENCY  = 1,
  parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
  input  logic         sysClk,
  input  logic         usrReset_n,
  input  logic         SS,
  input  logic         rxValid,
  input  logic [7:0]   rx,
  output logic [7:0]   tx,
  output logic         errAbort,
  output logic         errOverrun,
  spi_msg_if_if.master bus
);
  localparam int         W        = 8 * DATA_BYTES;
  localparam logic [2:0] LAST_CNT = 3'(DATA_BYTES - 1);

  typedef enum logic [2:0] {IDLE, HDR, WDATA, RDATA, DONE} state_t;

  state_t                  state_q, state_nxt;
  logic                    ss_meta_p0, ss_act_p1, ss_prev_p2;
  logic                    ss_fall;
  logic                    rx_acc;
  logic [2:0]              cnt_q;
  logic [6:0]              addr_q;
  logic [W-1:0]            wr_sr_q, wr_sr_nxt;
  logic [W-1:0]            tx_sr_q;
  logic [RD_LATENCY-1:0]   rd_pipe_q;
  logic                    hdr_take, wr_take, wr_last, rd_take, ovr, abort;

  // SS synchroniser and edge history
  always_ff @(posedge sysClk or negedge usrReset_n) begin
    if (!usrReset_n) begin
      ss_meta_p0 <= 1'b0;
      ss_act_p1  <= 1'b0;
      ss_prev_p2 <= 1'b0;
    end else begin
      ss_meta_p0 <= ~SS;
      ss_act_p1  <= ss_meta_p0;
      ss_prev_p2 <= ss_act_p1;
    end
  end

  // A byte landing on the same cycle the select drops is still processed.
  assign ss_fall   = ss_prev_p2 & ~ss_act_p1;
  assign rx_acc    = rxValid & (ss_act_p1 | ss_prev_p2);
  assign wr_sr_nxt = (wr_sr_q << 8) | W'(rx);

  always_ff @(posedge sysClk or negedge usrReset_n) begin
    if (!usrReset_n) state_q <= IDLE;
    else             state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    hdr_take  = 1'b0;
    wr_take   = 1'b0;
    wr_last   = 1'b0;
    rd_take   = 1'b0;
    ovr       = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE:  if (ss_act_p1) state_nxt = HDR;
      HDR:   if (rx_acc) begin
               hdr_take  = 1'b1;
               state_nxt = rx[7] ? RDATA : WDATA;
             end
      WDATA: if (rx_acc) begin
               wr_take = 1'b1;
               if (cnt_q == LAST_CNT) begin
                 wr_last   = 1'b1;
                 state_nxt = DONE;
               end
             end
      RDATA: if (rx_acc) begin
               rd_take = 1'b1;
               if (cnt_q == LAST_CNT) state_nxt = DONE;
             end
      DONE:  if (rx_acc) ovr = 1'b1;
      default: state_nxt = IDLE;
    endcase
    // Abort is judged on the state after this cycle's byte has been applied.
    if (ss_fall) begin
      abort     = (state_nxt == WDATA) || (state_nxt == RDATA);
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge sysClk or negedge usrReset_n) begin
    if (!usrReset_n) begin
      cnt_q       <= '0;
      addr_q      <= '0;
      wr_sr_q     <= '0;
      tx_sr_q     <= '0;
      rd_pipe_q   <= '0;
      bus.wrEn    <= 1'b0;
      bus.wrAddr  <= '0;
      bus.wrData  <= '0;
      bus.rdReq   <= 1'b0;
      bus.rdAddr  <= '0;
      errAbort    <= 1'b0;
      errOverrun  <= 1'b0;
    end else begin
      bus.wrEn   <= wr_last;
      bus.rdReq  <= hdr_take & rx[7];
      errAbort   <= abort;
      errOverrun <= ovr;
      rd_pipe_q  <= (rd_pipe_q << 1) | RD_LATENCY'(bus.rdReq);
      if (hdr_take) begin
        addr_q  <= rx[6:0];
        cnt_q   <= '0;
        tx_sr_q <= '0;
        if (rx[7]) bus.rdAddr <= rx[6:0];
      end
      if (wr_take) begin
        wr_sr_q <= wr_sr_nxt;
        cnt_q   <= cnt_q + 3'd1;
      end
      if (wr_last) begin
        bus.wrData <= wr_sr_nxt;
        bus.wrAddr <= addr_q;
      end
      if (rd_pipe_q[RD_LATENCY-1]) tx_sr_q <= bus.rdData;
      else if (rd_take) begin
        tx_sr_q <= tx_sr_q << 8;
        cnt_q   <= cnt_q + 3'd1;
      end
    end
  end

  always_comb begin
    tx = STATUS_BYTE;
    if (state_q == RDATA) tx = tx_sr_q[W-1 -: 8];
  end
endmodule
